reg_snapshot_streamer: RTL

Hardware producer for the CPU state dumps consumed by simulation. When the pipeline reaches a trigger PC or a manual request is made, the block stalls the CPU and walks the register-file debug port (`reg_sel`/`reg_data`). It then streams a framed snapshot out over a valid/ready word interface: the PC, then rf[0..31], with rf[0] forced to 0. It sits in `sccomp` beside `U_SCPU` and drives the same debug port a board-level monitor would use.

---
 rtl/reg_snapshot_streamer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reg_snapshot_streamer.sv
// rtl/reg_snapshot_streamer.sv - CPU register-file snapshot framer over a valid/ready word stream
// Optional build macro: SNAP_CYCLE_STAMP_EN inserts a trigger-time cycle stamp after the PC word.
module reg_snapshot_streamer #(
    parameter logic [31:0] TRIG_PC = 32'h00000198
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    input  logic        snap_req,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic        stall_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic [7:0]  drop_cnt,
    output logic [15:0] snap_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
`ifdef SNAP_CYCLE_STAMP_EN
        S_STAMP,
`endif
        S_REGS,
        S_DRAIN
    } state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic [31:0] pc_lat_q;
    logic [31:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic [7:0]  drop_q;
    logic [15:0] snap_q;
`ifdef SNAP_CYCLE_STAMP_EN
    logic [31:0] cyc_q;
    logic [31:0] stamp_q;
`endif

    logic        trig_d;
    logic        load_d;
    logic [31:0] reg_word_d;

    assign trig_d     = snap_req || (pc_valid && (pc_in == TRIG_PC));
    assign load_d     = !out_valid_q || out_ready;
    // rf[0] is reported as zero regardless of what the debug port returns.
    assign reg_word_d = (idx_q == 5'd0) ? 32'd0 : reg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            pc_lat_q    <= 32'd0;
            out_data_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 8'd0;
            snap_q      <= 16'd0;
`ifdef SNAP_CYCLE_STAMP_EN
            cyc_q       <= 32'd0;
            stamp_q     <= 32'd0;
`endif
        end else begin
`ifdef SNAP_CYCLE_STAMP_EN
            cyc_q <= cyc_q + 32'd1;
`endif
            if (busy_q && trig_d && (drop_q != 8'hff)) begin
                drop_q <= drop_q + 8'd1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trig_d) begin
                        pc_lat_q <= pc_in;
                        busy_q   <= 1'b1;
                        state_q  <= S_HDR;
`ifdef SNAP_CYCLE_STAMP_EN
                        stamp_q  <= cyc_q;
`endif
                    end
                end
                S_HDR: begin
                    if (load_d) begin
                        out_data_q  <= pc_lat_q;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        idx_q       <= 5'd0;
`ifdef SNAP_CYCLE_STAMP_EN
                        state_q     <= S_STAMP;
`else
                        state_q     <= S_REGS;
`endif
                    end
                end
`ifdef SNAP_CYCLE_STAMP_EN
                S_STAMP: begin
                    if (load_d) begin
                        out_data_q  <= stamp_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_REGS;
                    end
                end
`endif
                S_REGS: begin
                    if (load_d) begin
                        out_data_q  <= reg_word_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (idx_q == 5'd31);
                        idx_q       <= idx_q + 5'd1;
                        if (idx_q == 5'd31) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        snap_q      <= snap_q + 16'd1;
                        idx_q       <= 5'd0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reg_sel   = (state_q == S_REGS) ? idx_q : 5'd0;
    assign stall_req = busy_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign drop_cnt  = drop_q;
    assign snap_cnt  = snap_q;

endmodule
